// File: rtl/ddr3_bridge_pkg.sv
// Shared types and constants for the CPU-to-DDR3 command bridge.
package ddr3_bridge_pkg;

  localparam int BEAT_W      = 128;
  localparam int LANE_W      = 64;
  localparam int LANE_STRB_W = LANE_W / 8;
  localparam int BEAT_MASK_W = BEAT_W / 8;
  localparam int LANES       = BEAT_W / LANE_W;

  localparam logic [2:0] WT_CMD = 3'd0;
  localparam logic [2:0] RD_CMD = 3'd1;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WR_CMD,
    ST_WR_DATA,
    ST_RD_CMD,
    ST_RD_WAIT,
    ST_RESP
  } state_t;

endpackage

// File: rtl/ddr3_cmd_bridge_if.sv
// CPU-side request/response bundle of the DDR3 command bridge.
interface ddr3_cmd_bridge_if
  import ddr3_bridge_pkg::*;
;
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_we;
  logic [31:0]            req_addr;
  logic [LANE_W-1:0]      req_wdata;
  logic [LANE_STRB_W-1:0] req_wstrb;
  logic                   rsp_valid;
  logic [LANE_W-1:0]      rsp_rdata;
  logic                   rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/ddr3_lane_mux.sv
// Places a 64-bit word and its strobes into one lane of a 128-bit beat and
// selects the matching lane of a returned read beat.
module ddr3_lane_mux
  import ddr3_bridge_pkg::*;
(
  input  logic                   lane,
  input  logic [LANE_W-1:0]      wdata,
  input  logic [LANE_STRB_W-1:0] wstrb,
  input  logic [BEAT_W-1:0]      rd_data,
  output logic [BEAT_W-1:0]      wr_data,
  output logic [BEAT_MASK_W-1:0] wr_data_mask,
  output logic [LANE_W-1:0]      rd_lane
);
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      // Data goes to every lane; only the mask decides which bytes land.
      assign wr_data[gi*LANE_W +: LANE_W] = wdata;
      assign wr_data_mask[gi*LANE_STRB_W +: LANE_STRB_W] =
        (int'(lane) == gi) ? wstrb : '0;
    end
  endgenerate

  assign rd_lane = lane ? rd_data[BEAT_W-1 -: LANE_W] : rd_data[LANE_W-1:0];
endmodule

// File: rtl/ddr3_cmd_bridge.sv
// CPU-to-DDR3 app-interface bridge: each 64-bit access becomes one single-beat
// 128-bit command. Defining DDR3_BRIDGE_TIMEOUT_EN adds a read-wait timeout.
module ddr3_cmd_bridge
  import ddr3_bridge_pkg::*;
#(
  parameter int ADDR_W         = 28,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  ddr3_cmd_bridge_if.slave       cpu,
  output logic [2:0]             cmd,
  output logic                   cmd_en,
  output logic [ADDR_W-1:0]      addr,
  input  logic                   cmd_ready,
  input  logic                   init_calib_complete,
  output logic [BEAT_W-1:0]      wr_data,
  output logic                   wr_data_en,
  output logic                   wr_data_end,
  output logic [BEAT_MASK_W-1:0] wr_data_mask,
  input  logic                   wr_data_rdy,
  input  logic [BEAT_W-1:0]      rd_data,
  input  logic                   rd_data_valid,
  input  logic                   rd_data_end,
  output logic [5:0]             app_burst_number
);
  state_t                 state_reg, state_next;
  logic                   lane_reg;
  logic [27:0]            beat_reg;
  logic [LANE_W-1:0]      wdata_reg;
  logic [LANE_W-1:0]      rdata_reg;
  logic [LANE_W-1:0]      rd_lane;
  logic [LANE_STRB_W-1:0] wstrb_reg;
  logic                   accept;
  logic                   rd_hit;
  logic                   timeout;
  logic                   unused_bits;

  assign cpu.req_ready = !rst && (state_reg == ST_IDLE) && init_calib_complete;
  assign accept        = cpu.req_ready && cpu.req_valid;
  assign rd_hit        = (state_reg == ST_RD_WAIT) && rd_data_valid;
  assign unused_bits   = ^{cpu.req_addr[2:0], rd_data_end};

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_INIT;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_INIT:    if (init_calib_complete) state_next = ST_IDLE;
      ST_IDLE: begin
        if (!init_calib_complete) state_next = ST_INIT;
        else if (cpu.req_valid)   state_next = cpu.req_we ? ST_WR_CMD : ST_RD_CMD;
      end
      ST_WR_CMD:  if (cmd_ready)   state_next = ST_WR_DATA;
      ST_WR_DATA: if (wr_data_rdy) state_next = ST_RESP;
      ST_RD_CMD:  if (cmd_ready)   state_next = ST_RD_WAIT;
      ST_RD_WAIT: if (rd_data_valid || timeout) state_next = ST_RESP;
      ST_RESP:    state_next = ST_IDLE;
      default:    state_next = ST_INIT;
    endcase
  end

  // Response data is cleared on acceptance so writes and timeouts return zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_reg  <= 1'b0;
      beat_reg  <= '0;
      wdata_reg <= '0;
      wstrb_reg <= '0;
      rdata_reg <= '0;
    end else begin
      if (accept) begin
        lane_reg  <= cpu.req_addr[3];
        beat_reg  <= cpu.req_addr[31:4];
        wdata_reg <= cpu.req_wdata;
        wstrb_reg <= cpu.req_wstrb;
        rdata_reg <= '0;
      end
      if (rd_hit) rdata_reg <= rd_lane;
    end
  end

  ddr3_lane_mux u_lane_mux (
    .lane         (lane_reg),
    .wdata        (wdata_reg),
    .wstrb        (wstrb_reg),
    .rd_data      (rd_data),
    .wr_data      (wr_data),
    .wr_data_mask (wr_data_mask),
    .rd_lane      (rd_lane)
  );

  assign cmd_en      = !rst && ((state_reg == ST_WR_CMD) || (state_reg == ST_RD_CMD)) && cmd_ready;
  assign cmd         = (!rst && state_reg == ST_RD_CMD) ? RD_CMD : WT_CMD;
  assign addr        = ADDR_W'(beat_reg);
  assign wr_data_en  = !rst && (state_reg == ST_WR_DATA) && wr_data_rdy;
  assign wr_data_end = wr_data_en;
  assign app_burst_number = 6'd0;

  assign cpu.rsp_valid = !rst && (state_reg == ST_RESP);
  assign cpu.rsp_rdata = rdata_reg;

`ifdef DDR3_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_reg;
  logic             err_reg;

  // Counter idles at zero outside RD_WAIT, so it starts fresh on every entry.
  always_ff @(posedge clk) begin
    if (rst || state_reg != ST_RD_WAIT) wait_cnt_reg <= '0;
    else                                wait_cnt_reg <= wait_cnt_reg + 1'b1;
  end

  assign timeout = (state_reg == ST_RD_WAIT) && !rd_data_valid &&
                   (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst)          err_reg <= 1'b0;
    else if (accept)  err_reg <= 1'b0;
    else if (timeout) err_reg <= 1'b1;
  end

  assign cpu.rsp_err = !rst && err_reg && (state_reg == ST_RESP);
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign timeout     = 1'b0;
  assign cpu.rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_ddr3_cmd_bridge.sv
// Self-checking bench for ddr3_cmd_bridge: directed and randomized transactions
// against a cycle-count reference model of an ideal DDR3 controller.
module tb_ddr3_cmd_bridge;
  localparam int ADDR_W  = 28;
  localparam int TIMEOUT = 255;

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        cmd;
  logic              cmd_en;
  logic [ADDR_W-1:0] addr;
  logic              cmd_ready, init_calib_complete;
  logic [127:0]      wr_data;
  logic              wr_data_en, wr_data_end;
  logic [15:0]       wr_data_mask;
  logic              wr_data_rdy;
  logic [127:0]      rd_data;
  logic              rd_data_valid, rd_data_end;
  logic [5:0]        app_burst_number;

  int compared   = 0;
  int mismatched = 0;
  int txn_id     = 0;

  ddr3_cmd_bridge_if cpu ();

  ddr3_cmd_bridge #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .cpu                 (cpu),
    .cmd                 (cmd),
    .cmd_en              (cmd_en),
    .addr                (addr),
    .cmd_ready           (cmd_ready),
    .init_calib_complete (init_calib_complete),
    .wr_data             (wr_data),
    .wr_data_en          (wr_data_en),
    .wr_data_end         (wr_data_end),
    .wr_data_mask        (wr_data_mask),
    .wr_data_rdy         (wr_data_rdy),
    .rd_data             (rd_data),
    .rd_data_valid       (rd_data_valid),
    .rd_data_end         (rd_data_end),
    .app_burst_number    (app_burst_number)
  );

  always #5 clk = ~clk;

  // One CPU transaction served by an ideal controller that stalls cmd_ready for
  // cd cycles, wr_data_rdy for wdl cycles and returns read data rdl cycles after
  // the command (rdl < 0: never). Expected cycle numbers count from acceptance.
  task automatic run_txn(input bit we, input logic [31:0] a, input logic [63:0] wd,
                         input logic [7:0] ws, input int cd, input int wdl, input int rdl,
                         input logic [127:0] rdat, input bit junk_rd);
    int k, wait_n, kc, kw, rsp_k, kr_drive, bound;
    int cmd_cnt, wen_cnt, rsp_cnt, end_bad, rdy_bad;
    int kc_exp, kw_exp, rsp_exp;
    logic [2:0]   got_cmd;
    logic [ADDR_W-1:0] got_addr;
    logic [127:0] got_wdata, shifted;
    logic [15:0]  got_mask, exp_mask;
    logic [63:0]  got_rdata, exp_rdata;
    logic         got_err, exp_err, lane;
    bit           done;

    lane   = a[3];
    kc_exp = 1 + cd;
    kw_exp = kc_exp + 1 + wdl;
    if (we) begin
      rsp_exp   = kw_exp + 1;
      exp_mask  = 16'(ws) << (8 * lane);
      exp_rdata = '0;
      exp_err   = 1'b0;
    end else if (rdl >= 0) begin
      rsp_exp   = kc_exp + 1 + rdl + 1;
      shifted   = rdat >> (64 * lane);
      exp_rdata = shifted[63:0];
      exp_err   = 1'b0;
      exp_mask  = '0;
    end else begin
      rsp_exp   = kc_exp + 1 + TIMEOUT;
      exp_rdata = '0;
      exp_err   = 1'b1;
      exp_mask  = '0;
    end
    bound = rsp_exp + 10;

    cpu.req_valid = 1'b1; cpu.req_we = we; cpu.req_addr = a;
    cpu.req_wdata = wd;   cpu.req_wstrb = ws;
    cmd_ready = 1'b0; wr_data_rdy = 1'b0; rd_data_end = 1'b0;
    rd_data_valid = junk_rd; rd_data = {$urandom, $urandom, $urandom, $urandom};
    cmd_cnt = 0; wen_cnt = 0; rsp_cnt = 0; end_bad = 0; rdy_bad = 0;
    kc = -1; kw = -1; rsp_k = -1; kr_drive = -1; done = 0;
    got_cmd = 'x; got_addr = 'x; got_wdata = 'x; got_mask = 'x; got_rdata = 'x; got_err = 'x;

    wait_n = 0;
    @(negedge clk);
    while (cpu.req_ready !== 1'b1 && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    compared++;
    if (wait_n != 0 || cpu.req_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL accept: waited %0d cycles, req_ready=%b, required ready at once", wait_n, cpu.req_ready);
    end
    if (cpu.req_ready !== 1'b1) begin
      @(posedge clk); #1;
      cpu.req_valid = 1'b0; rd_data_valid = 1'b0;
      return;
    end
    if (cpu.rsp_valid !== 1'b0) rsp_cnt++;
    @(posedge clk); #1;
    cpu.req_valid = 1'b0; cpu.req_we = $urandom_range(0, 1);
    cpu.req_addr = $urandom; cpu.req_wdata = {$urandom, $urandom}; cpu.req_wstrb = 8'($urandom);

    k = 1;
    while (!done && k <= bound) begin
      cmd_ready   = (k >= 1 + cd);
      wr_data_rdy = we && (kc >= 0) && (k >= kc + 1 + wdl);
      rd_data_end = 1'b0;
      if (!we && kc >= 0 && rdl >= 0 && k == kc + 1 + rdl) begin
        rd_data_valid = 1'b1; rd_data = rdat; rd_data_end = 1'b1; kr_drive = k;
      end else begin
        rd_data_valid = junk_rd && (we || kc < 0) && $urandom_range(0, 1) == 1;
        rd_data = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      if (cmd_en === 1'b1) begin
        cmd_cnt++;
        if (kc < 0) begin kc = k; got_cmd = cmd; got_addr = addr; end
      end
      if (wr_data_en !== wr_data_end) end_bad++;
      if (wr_data_en === 1'b1) begin
        wen_cnt++;
        if (kw < 0) begin kw = k; got_wdata = wr_data; got_mask = wr_data_mask; end
      end
      if (cpu.req_ready !== 1'b0) rdy_bad++;
      if (cpu.rsp_valid === 1'b1) begin
        rsp_cnt++;
        if (rsp_k < 0) begin rsp_k = k; got_rdata = cpu.rsp_rdata; got_err = cpu.rsp_err; end
      end
      @(posedge clk); #1;
      if (rsp_k >= 0) done = 1;
      k++;
    end
    rd_data_valid = 1'b0; rd_data_end = 1'b0; cmd_ready = 1'b0; wr_data_rdy = 1'b0;

    compared++;
    if (cmd_cnt !== 1) begin mismatched++; $display("FAIL cmd_count: got %0d, required 1", cmd_cnt); end
    compared++;
    if (kc !== kc_exp) begin mismatched++; $display("FAIL cmd_cycle: got %0d, required %0d", kc, kc_exp); end
    compared++;
    if (got_cmd !== (we ? 3'd0 : 3'd1)) begin mismatched++; $display("FAIL cmd_code: got %0d, required %0d", got_cmd, we ? 0 : 1); end
    compared++;
    if (got_addr !== ADDR_W'(a >> 4)) begin mismatched++; $display("FAIL cmd_addr: got %h, required %h", got_addr, ADDR_W'(a >> 4)); end
    compared++;
    if (wen_cnt !== (we ? 1 : 0)) begin mismatched++; $display("FAIL wdata_count: got %0d, required %0d", wen_cnt, we ? 1 : 0); end
    compared++;
    if (end_bad !== 0) begin mismatched++; $display("FAIL wdata_end: %0d cycles with wr_data_end != wr_data_en, required 0", end_bad); end
    if (we) begin
      compared++;
      if (kw !== kw_exp) begin mismatched++; $display("FAIL wdata_cycle: got %0d, required %0d", kw, kw_exp); end
      compared++;
      if (got_wdata !== {wd, wd}) begin mismatched++; $display("FAIL wr_data: got %h, required %h", got_wdata, {wd, wd}); end
      compared++;
      if (got_mask !== exp_mask) begin mismatched++; $display("FAIL wr_mask: got %h, required %h", got_mask, exp_mask); end
    end
    compared++;
    if (rsp_cnt !== 1) begin mismatched++; $display("FAIL rsp_count: got %0d, required 1", rsp_cnt); end
    compared++;
    if (rsp_k !== rsp_exp) begin mismatched++; $display("FAIL rsp_cycle: got %0d, required %0d", rsp_k, rsp_exp); end
    compared++;
    if (got_rdata !== exp_rdata) begin mismatched++; $display("FAIL rsp_rdata: got %h, required %h", got_rdata, exp_rdata); end
    compared++;
    if (got_err !== exp_err) begin mismatched++; $display("FAIL rsp_err: got %b, required %b", got_err, exp_err); end
    compared++;
    if (rdy_bad !== 0) begin mismatched++; $display("FAIL busy_ready: req_ready high in %0d busy cycles, required 0", rdy_bad); end

    txn_id++;
    $display("txn %0d: we=%0d addr=%h cmd_cycle=%0d rsp_cycle=%0d rdata=%h err=%b read_pulse=%0d",
             txn_id, we, a, kc, rsp_k, got_rdata, got_err, kr_drive);
  endtask

  task automatic test_reset;
    rst = 1'b1; init_calib_complete = 1'b1; cmd_ready = 1'b1; wr_data_rdy = 1'b1;
    rd_data_valid = 1'b1; rd_data = '1; rd_data_end = 1'b1;
    cpu.req_valid = 1'b1; cpu.req_we = 1'b1; cpu.req_addr = 32'hFFFF_FFFF;
    cpu.req_wdata = '1; cpu.req_wstrb = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    compared++;
    if ({cpu.req_ready, cpu.rsp_valid, cpu.rsp_err, cmd_en, wr_data_en, wr_data_end} !== 6'b0) begin
      mismatched++;
      $display("FAIL reset_strobes: ready/rsp/err/cmd_en/wen/wend=%b, required 000000",
               {cpu.req_ready, cpu.rsp_valid, cpu.rsp_err, cmd_en, wr_data_en, wr_data_end});
    end
    @(posedge clk); #1;
    rst = 1'b0; cpu.req_valid = 1'b0; rd_data_valid = 1'b0; rd_data_end = 1'b0;
    cmd_ready = 1'b0; wr_data_rdy = 1'b0;
    @(negedge clk);
    compared++;
    if ({cpu.rsp_rdata, wr_data, wr_data_mask, addr, cmd} !== '0) begin
      mismatched++;
      $display("FAIL reset_values: rdata=%h wr_data=%h mask=%h addr=%h cmd=%0d, required all 0",
               cpu.rsp_rdata, wr_data, wr_data_mask, addr, cmd);
    end
    compared++;
    if (cpu.req_ready !== 1'b0) begin mismatched++; $display("FAIL init_ready: got %b, required 0", cpu.req_ready); end
    compared++;
    if (app_burst_number !== 6'd0) begin mismatched++; $display("FAIL burst_number: got %0d, required 0", app_burst_number); end
    @(negedge clk);
    compared++;
    if (cpu.req_ready !== 1'b1) begin mismatched++; $display("FAIL idle_ready: got %b, required 1", cpu.req_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_calib_hold;
    int rdy_hits, cmd_hits;
    rdy_hits = 0; cmd_hits = 0;
    init_calib_complete = 1'b0; cmd_ready = 1'b1; wr_data_rdy = 1'b1;
    cpu.req_valid = 1'b1; cpu.req_we = 1'b1; cpu.req_addr = 32'h40;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cpu.req_ready !== 1'b0) rdy_hits++;
      if (cmd_en !== 1'b0 || wr_data_en !== 1'b0) cmd_hits++;
      @(posedge clk); #1;
    end
    compared++;
    if (rdy_hits !== 0) begin mismatched++; $display("FAIL calib_ready: req_ready high %0d cycles, required 0", rdy_hits); end
    compared++;
    if (cmd_hits !== 0) begin mismatched++; $display("FAIL calib_cmd: strobes seen %0d cycles, required 0", cmd_hits); end
    cpu.req_valid = 1'b0; cmd_ready = 1'b0; wr_data_rdy = 1'b0; init_calib_complete = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    compared++;
    if (cpu.req_ready !== 1'b1) begin mismatched++; $display("FAIL calib_recover: req_ready=%b, required 1", cpu.req_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_write_directed;
    run_txn(1'b1, 32'h0000_0018, 64'h1122_3344_5566_7788, 8'hFF, 0, 0, 0, '0, 1'b0);
    run_txn(1'b1, 32'h0000_0100, 64'hDEAD_BEEF_0BAD_F00D, 8'h0F, 0, 2, 0, '0, 1'b1);
  endtask

  task automatic test_read_directed;
    run_txn(1'b0, 32'h0000_0018, '0, '0, 0, 0, 4,
            {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555}, 1'b1);
    run_txn(1'b0, 32'h0000_0010, '0, '0, 0, 0, 0,
            {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555}, 1'b0);
  endtask

  task automatic test_cmd_backpressure;
    run_txn(1'b1, 32'h1234_5678, 64'h0102_0304_0506_0708, 8'hA5, 10, 1, 0, '0, 1'b0);
    run_txn(1'b0, 32'hFFFF_FFF8, '0, '0, 10, 0, 3, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      run_txn(1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom}, 8'($urandom),
              $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 6),
              {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 6; i++) begin
      run_txn(1'(i % 2), $urandom, {$urandom, $urandom}, 8'($urandom), 0, 0, 0,
              {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    end
  endtask

  task automatic test_reset_in_rd_wait;
    int strobe_hits;
    strobe_hits = 0;
    cpu.req_valid = 1'b1; cpu.req_we = 1'b0; cpu.req_addr = 32'h0000_0208;
    cmd_ready = 1'b1;
    @(negedge clk);
    compared++;
    if (cpu.req_ready !== 1'b1) begin mismatched++; $display("FAIL abort_accept: req_ready=%b, required 1", cpu.req_ready); end
    @(posedge clk); #1;
    cpu.req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    compared++;
    if ({cpu.req_ready, cpu.rsp_valid, cpu.rsp_err, cmd_en, wr_data_en, wr_data_end} !== 6'b0) begin
      mismatched++;
      $display("FAIL abort_strobes: ready/rsp/err/cmd_en/wen/wend=%b, required 000000",
               {cpu.req_ready, cpu.rsp_valid, cpu.rsp_err, cmd_en, wr_data_en, wr_data_end});
    end
    @(posedge clk); #1;
    rst = 1'b0; wr_data_rdy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      rd_data_valid = 1'b1; rd_data = {$urandom | 32'h1, $urandom, $urandom, $urandom | 32'h1};
      @(negedge clk);
      if (cmd_en !== 1'b0 || wr_data_en !== 1'b0 || wr_data_end !== 1'b0 || cpu.rsp_valid !== 1'b0)
        strobe_hits++;
      @(posedge clk); #1;
    end
    rd_data_valid = 1'b0; cmd_ready = 1'b0; wr_data_rdy = 1'b0;
    @(negedge clk);
    compared++;
    if (strobe_hits !== 0) begin mismatched++; $display("FAIL abort_quiet: strobes in %0d cycles, required 0", strobe_hits); end
    compared++;
    if (cpu.rsp_rdata !== 64'd0) begin mismatched++; $display("FAIL abort_rdata: got %h, required 0", cpu.rsp_rdata); end
    compared++;
    if (cpu.req_ready !== 1'b1) begin mismatched++; $display("FAIL abort_ready: got %b, required 1", cpu.req_ready); end
    @(posedge clk); #1;
    run_txn(1'b0, 32'h0000_0208, '0, '0, 0, 0, 1, {64'h0F0F_0F0F_0F0F_0F0F, 64'h1234_5678_9ABC_DEF0}, 1'b0);
  endtask

`ifdef DDR3_BRIDGE_TIMEOUT_EN
  task automatic test_timeout;
    run_txn(1'b0, 32'h0000_0030, '0, '0, 0, 0, -1, '0, 1'b0);
  endtask
`endif

  initial begin
    rst = 1'b1; init_calib_complete = 1'b0; cmd_ready = 1'b0; wr_data_rdy = 1'b0;
    rd_data = '0; rd_data_valid = 1'b0; rd_data_end = 1'b0;
    cpu.req_valid = 1'b0; cpu.req_we = 1'b0; cpu.req_addr = '0;
    cpu.req_wdata = '0; cpu.req_wstrb = '0;
    test_reset;
    test_calib_hold;
    test_write_directed;
    test_read_directed;
    test_cmd_backpressure;
    test_random;
    test_back_to_back;
    test_reset_in_rd_wait;
`ifdef DDR3_BRIDGE_TIMEOUT_EN
    test_timeout;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
